fft4_power_serializer: RTL and testbench
========================================

Name: fft4_power_serializer

Overview:
Downstream consumer of the 4-point streaming FFT core. Captures one frame of four parallel complex bins (16-bit re/im) on a single-cycle valid strobe. Streams the bins out one per beat over a valid/ready interface, each beat annotated with bin index and power |X|^2. Holds up to two frames in a ping-pong buffer and publishes the peak-power bin once per frame.

Parameters:
IN_W, 16, width of each signed re/im input component
PWR_W, 32, width of unsigned power output (must equal 2*IN_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
frame_valid  in  1  one-cycle strobe: yr0..yr3/yi0..yi3 hold a complete frame
yr0..yr3  in  IN_W each  signed real part, bins 0..3
yi0..yi3  in  IN_W each  signed imaginary part, bins 0..3
frame_ready  out  1  combinational: buffer has a free frame slot
frame_drop  out  1  registered one-cycle pulse: frame_valid arrived while frame_ready=0
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_bin  out  2  bin index of current beat
m_re, m_im  out  IN_W  signed bin value
m_power  out  PWR_W  unsigned re^2+im^2
m_last  out  1  high on the bin-3 beat
peak_valid  out  1  one-cycle pulse, peak result for the frame just completed
peak_bin  out  2  index of max-power bin
peak_power  out  PWR_W  max power value

Behaviour:
- Reset (async): all outputs 0; buffer count 0; read/write pointers 0; running max 0. frame_ready=1 after reset. Reset mid-frame discards all buffered and partial frames with no peak_valid.
- Buffer: 2 frame slots of 8 x IN_W, written whole in one cycle. frame_ready = (count != 2). Accept = frame_valid && frame_ready; write slot wr_ptr, toggle wr_ptr, count+1.
- Drop: frame_valid && !frame_ready -> frame ignored, frame_drop=1 on the next cycle only.
- Output register: loads when (!m_valid || m_ready) and count != 0. Loads bin rd_bin of slot rd_ptr, with m_power computed from that bin. rd_bin increments 0->3; m_last = (rd_bin==3).
- Loading bin 3 frees its slot: rd_ptr toggles, rd_bin wraps to 0, count-1. Simultaneous accept and free in one cycle leaves count unchanged.
- If the output register is free and nothing loads, m_valid clears.
- Latency: frame accepted at edge E0 -> m_valid=1 with bin0 after E0+1. With m_ready held high, bins follow on consecutive cycles with no bubbles, including back-to-back frames.
- m_ready=0 with m_valid=1: all m_* outputs hold stable.
- Power: sign-extend, square each component, add, unsigned PWR_W. Maximum is 2^31 at (-32768,-32768) and must not wrap.
- Peak: running max updates as each beat transfers (m_valid && m_ready). Strict greater-than, so ties keep the lowest bin index.
- On transfer of the m_last beat: peak_bin/peak_power take the final max, peak_valid pulses 1 cycle later, and the running max resets to bin-next. peak_bin/peak_power hold until the next frame completes.
- frame_valid and m_ready may both be active in the same cycle as a final-beat load; all three events take effect independently.

Decomposition:
- Shared package fft4_pkg holds: IN_W/PWR_W defaults, NUM_BINS=4, BIN_IDX_W=2, complex_bin typedef (signed re, im), frame typedef (array of 4 complex_bin).
- Natural sub-module: cplx_power (combinational, re^2+im^2 with correct width extension), instantiated once on the read path.

Test Plan:
- Single frame: bins (3,4),(0,0),(-5,12),(1,1), m_ready=1. Expect 4 beats on consecutive cycles with powers 25,0,169,2, m_last on bin3, then peak_valid with peak_bin=2, peak_power=169.
- Extreme value: bin0=(-32768,-32768), others 0. Expect m_power=32'h8000_0000 and peak_bin=0.
- Tie handling: all bins (0,0). Expect powers 0, peak_bin=0, peak_power=0. Then bins (2,0),(0,2),(-2,0),(0,-2): all powers 4, peak_bin=0.
- Backpressure/full: m_ready=0, send 2 frames -> frame_ready=0. A third frame_valid -> frame_drop pulse, frame discarded. Release m_ready -> exactly 8 beats from frames 1 then 2, with m_* stable during stalls.
- Back-to-back: frames every 4 cycles with m_ready=1. Expect a continuous m_valid stream, no drops, one peak_valid per frame.
- Reset mid-stream: assert rst during bin1 of frame 1 with frame 2 queued. Expect all outputs 0 immediately, no peak_valid, frame_ready=1. A new frame afterwards streams from bin0.

Source files
------------

// File: rtl/fft4_pkg.sv
// Shared types and widths for the 4-point FFT power serializer.
// Holds component/power widths, bin count, and the complex bin / frame payload types.
package fft4_pkg;

   localparam int unsigned IN_W      = 16;
   localparam int unsigned PWR_W     = 2 * IN_W;
   localparam int unsigned NUM_BINS  = 4;
   localparam int unsigned BIN_IDX_W = 2;

   typedef struct packed {
      logic signed [IN_W-1:0] re;
      logic signed [IN_W-1:0] im;
   } complex_bin;

   typedef complex_bin [NUM_BINS-1:0] frame;

endpackage

// File: rtl/fft4_power_serializer_cplx_power.sv
// Combinational |x|^2 = re^2 + im^2 for one complex bin.
// Ports: re, im (signed IN_W) in; power (unsigned PWR_W) out.
// Both squares are non-negative and at most 2^30, so their sum (max 2^31)
// fits the unsigned PWR_W result without wrapping.
module cplx_power
   import fft4_pkg::*;
(
   input  logic signed [IN_W-1:0] re,
   input  logic signed [IN_W-1:0] im,
   output logic [PWR_W-1:0]       power
);

   logic signed [PWR_W-1:0] re_x;
   logic signed [PWR_W-1:0] im_x;
   logic signed [PWR_W-1:0] re_sq;
   logic signed [PWR_W-1:0] im_sq;

   // sign-extend before squaring so the product is computed at full width
   assign re_x  = {{(PWR_W-IN_W){re[IN_W-1]}}, re};
   assign im_x  = {{(PWR_W-IN_W){im[IN_W-1]}}, im};
   assign re_sq = re_x * re_x;
   assign im_sq = im_x * im_x;
   assign power = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft4_power_serializer.sv
// Captures 4-bin complex FFT frames into a 2-slot ping-pong buffer and streams
// them out one bin per beat with power annotation; publishes per-frame peak bin.
// Ports: clk, rst (async, active-high); frame_valid, yr0..yr3, yi0..yi3 in;
// frame_ready (comb), frame_drop out; m_valid/m_ready handshake with m_bin,
// m_re, m_im, m_power, m_last; peak_valid, peak_bin, peak_power out.
module fft4_power_serializer
   import fft4_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_valid,
   input  logic signed [IN_W-1:0]      yr0,
   input  logic signed [IN_W-1:0]      yr1,
   input  logic signed [IN_W-1:0]      yr2,
   input  logic signed [IN_W-1:0]      yr3,
   input  logic signed [IN_W-1:0]      yi0,
   input  logic signed [IN_W-1:0]      yi1,
   input  logic signed [IN_W-1:0]      yi2,
   input  logic signed [IN_W-1:0]      yi3,
   output logic                        frame_ready,
   output logic                        frame_drop,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [BIN_IDX_W-1:0]        m_bin,
   output logic signed [IN_W-1:0]      m_re,
   output logic signed [IN_W-1:0]      m_im,
   output logic [PWR_W-1:0]            m_power,
   output logic                        m_last,
   output logic                        peak_valid,
   output logic [BIN_IDX_W-1:0]        peak_bin,
   output logic [PWR_W-1:0]            peak_power
);

   localparam logic [BIN_IDX_W-1:0] LAST_BIN = BIN_IDX_W'(NUM_BINS - 1);
   localparam logic [1:0]           FULL     = 2'd2;

   frame                 slots [2];
   frame                 in_frame_c;
   complex_bin           rd_sel_c;
   logic [1:0]           count;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [BIN_IDX_W-1:0] rd_bin;
   logic                 accept_c;
   logic                 load_c;
   logic                 free_c;
   logic                 xfer_c;
   logic [PWR_W-1:0]     rd_power_c;
   logic [PWR_W-1:0]     run_max;
   logic [BIN_IDX_W-1:0] run_bin;
   logic [PWR_W-1:0]     best_power_c;
   logic [BIN_IDX_W-1:0] best_bin_c;

   assign frame_ready = (count != FULL);
   assign accept_c    = frame_valid && frame_ready;
   assign load_c      = (!m_valid || m_ready) && (count != 2'd0);
   assign free_c      = load_c && (rd_bin == LAST_BIN);
   assign xfer_c      = m_valid && m_ready;

   // pack the parallel input bins into one frame word
   always_comb begin
      in_frame_c       = '0;
      in_frame_c[0].re = yr0;
      in_frame_c[0].im = yi0;
      in_frame_c[1].re = yr1;
      in_frame_c[1].im = yi1;
      in_frame_c[2].re = yr2;
      in_frame_c[2].im = yi2;
      in_frame_c[3].re = yr3;
      in_frame_c[3].im = yi3;
   end

   assign rd_sel_c = slots[rd_ptr][rd_bin];

   cplx_power u_power (
      .re    (rd_sel_c.re),
      .im    (rd_sel_c.im),
      .power (rd_power_c)
   );

   // strict greater-than keeps the lowest index on ties
   always_comb begin
      best_power_c = run_max;
      best_bin_c   = run_bin;
      if (m_power > run_max) begin
         best_power_c = m_power;
         best_bin_c   = m_bin;
      end
   end

   // frame storage: data only, no reset needed
   always_ff @(posedge clk) begin
      if (accept_c) slots[wr_ptr] <= in_frame_c;
   end

   // buffer bookkeeping and drop flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         rd_bin     <= '0;
         frame_drop <= 1'b0;
      end else begin
         frame_drop <= frame_valid && !frame_ready;
         if (accept_c) wr_ptr <= ~wr_ptr;
         if (load_c) begin
            rd_bin <= rd_bin + 1'b1;
            if (free_c) rd_ptr <= ~rd_ptr;
         end
         case ({accept_c, free_c})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   // output beat register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_bin   <= '0;
         m_re    <= '0;
         m_im    <= '0;
         m_power <= '0;
         m_last  <= 1'b0;
      end else if (load_c) begin
         m_valid <= 1'b1;
         m_bin   <= rd_bin;
         m_re    <= rd_sel_c.re;
         m_im    <= rd_sel_c.im;
         m_power <= rd_power_c;
         m_last  <= (rd_bin == LAST_BIN);
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // running peak tracker, published on the final beat of each frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_max    <= '0;
         run_bin    <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_power <= '0;
      end else begin
         peak_valid <= 1'b0;
         if (xfer_c) begin
            if (m_last) begin
               peak_valid <= 1'b1;
               peak_bin   <= best_bin_c;
               peak_power <= best_power_c;
               run_max    <= '0;
               run_bin    <= '0;
            end else begin
               run_max    <= best_power_c;
               run_bin    <= best_bin_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft4_power_serializer.sv
// Directed self-checking bench for fft4_power_serializer.
// A negedge monitor records every transferred beat, peak pulse and drop, and
// checks output stability while stalled; each test compares the recordings
// against hand-computed beat and peak tables.
module tb_fft4_power_serializer;

   typedef struct {
      logic [1:0]  bin;
      logic [15:0] re;
      logic [15:0] im;
      logic [31:0] pwr;
      logic        last;
      int          cyc;
   } beat_t;

   typedef struct {
      logic [1:0]  bin;
      logic [31:0] pwr;
   } peak_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               frame_valid;
   logic signed [15:0] yr0, yr1, yr2, yr3, yi0, yi1, yi2, yi3;
   logic               frame_ready, frame_drop;
   logic               m_valid, m_ready, m_last;
   logic [1:0]         m_bin;
   logic signed [15:0] m_re, m_im;
   logic [31:0]        m_power;
   logic               peak_valid;
   logic [1:0]         peak_bin;
   logic [31:0]        peak_power;

   int n_checks = 0;
   int n_errors = 0;
   int n_drops  = 0;
   int cyc      = 0;

   beat_t got_beats [$];
   beat_t exp_beats [$];
   peak_t got_peaks [$];
   peak_t exp_peaks [$];

   logic        stalled = 1'b0;
   logic [34:0] prev_data;
   logic [32:0] prev_pwr;

   fft4_power_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .yr0         (yr0),
      .yr1         (yr1),
      .yr2         (yr2),
      .yr3         (yr3),
      .yi0         (yi0),
      .yi1         (yi1),
      .yi2         (yi2),
      .yi3         (yi3),
      .frame_ready (frame_ready),
      .frame_drop  (frame_drop),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_bin       (m_bin),
      .m_re        (m_re),
      .m_im        (m_im),
      .m_power     (m_power),
      .m_last      (m_last),
      .peak_valid  (peak_valid),
      .peak_bin    (peak_bin),
      .peak_power  (peak_power)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // record transfers, peaks, drops; verify stall stability
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_data", 64'({m_bin, m_re, m_im, m_last}), 64'(prev_data));
            check("stall_pwr", 64'({m_valid, m_power}), 64'(prev_pwr));
         end
         if (m_valid && m_ready)
            got_beats.push_back('{m_bin, m_re, m_im, m_power, m_last, cyc});
         if (peak_valid) got_peaks.push_back('{peak_bin, peak_power});
         if (frame_drop) n_drops++;
         stalled   = m_valid && !m_ready;
         prev_data = {m_bin, m_re, m_im, m_last};
         prev_pwr  = {m_valid, m_power};
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int r0, input int i0, input int r1, input int i1,
                             input int r2, input int i2, input int r3, input int i3);
      frame_valid = 1'b1;
      yr0 = 16'(r0); yi0 = 16'(i0);
      yr1 = 16'(r1); yi1 = 16'(i1);
      yr2 = 16'(r2); yi2 = 16'(i2);
      yr3 = 16'(r3); yi3 = 16'(i3);
      tick(1);
      frame_valid = 1'b0;
   endtask

   task automatic exp_beat(input int bin, input int re, input int im, input logic [31:0] pwr);
      exp_beats.push_back('{2'(bin), 16'(re), 16'(im), pwr, (bin == 3), 0});
   endtask

   task automatic exp_peak(input int bin, input logic [31:0] pwr);
      exp_peaks.push_back('{2'(bin), pwr});
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_nbeats"}, 64'(got_beats.size()), 64'(exp_beats.size()));
      for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++) begin
         check($sformatf("%s_b%0d_bin", tag, i), 64'(got_beats[i].bin), 64'(exp_beats[i].bin));
         check($sformatf("%s_b%0d_re", tag, i), 64'(got_beats[i].re), 64'(exp_beats[i].re));
         check($sformatf("%s_b%0d_im", tag, i), 64'(got_beats[i].im), 64'(exp_beats[i].im));
         check($sformatf("%s_b%0d_pwr", tag, i), 64'(got_beats[i].pwr), 64'(exp_beats[i].pwr));
         check($sformatf("%s_b%0d_last", tag, i), 64'(got_beats[i].last), 64'(exp_beats[i].last));
         if (i > 0)
            check($sformatf("%s_b%0d_gap", tag, i),
                  64'(got_beats[i].cyc - got_beats[i-1].cyc), 64'd1);
      end
      check({tag, "_npeaks"}, 64'(got_peaks.size()), 64'(exp_peaks.size()));
      for (int i = 0; i < got_peaks.size() && i < exp_peaks.size(); i++) begin
         check($sformatf("%s_p%0d_bin", tag, i), 64'(got_peaks[i].bin), 64'(exp_peaks[i].bin));
         check($sformatf("%s_p%0d_pwr", tag, i), 64'(got_peaks[i].pwr), 64'(exp_peaks[i].pwr));
      end
      got_beats.delete();
      exp_beats.delete();
      got_peaks.delete();
      exp_peaks.delete();
   endtask

   initial begin
      rst = 1'b1;
      frame_valid = 1'b0;
      m_ready = 1'b0;
      {yr0, yr1, yr2, yr3, yi0, yi1, yi2, yi3} = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_frame_ready", 64'(frame_ready), 64'd1);
      check("rst_frame_drop", 64'(frame_drop), 64'd0);
      check("rst_peak_valid", 64'(peak_valid), 64'd0);
      check("rst_m_power", 64'(m_power), 64'd0);
      check("rst_peak_power", 64'(peak_power), 64'd0);

      // single frame with latency and peak timing
      m_ready = 1'b1;
      send_frame(3, 4, 0, 0, -5, 12, 1, 1);
      check("lat_idle", 64'(m_valid), 64'd0);
      tick(1);
      check("lat_valid", 64'(m_valid), 64'd1);
      check("lat_bin", 64'(m_bin), 64'd0);
      check("lat_pwr", 64'(m_power), 64'd25);
      tick(4);
      check("pk_valid", 64'(peak_valid), 64'd1);
      check("pk_bin", 64'(peak_bin), 64'd2);
      check("pk_pwr", 64'(peak_power), 64'd169);
      check("pk_mvalid_clr", 64'(m_valid), 64'd0);
      tick(1);
      check("pk_pulse_end", 64'(peak_valid), 64'd0);
      check("pk_hold", 64'(peak_bin), 64'd2);
      exp_beat(0, 3, 4, 25); exp_beat(1, 0, 0, 0); exp_beat(2, -5, 12, 169); exp_beat(3, 1, 1, 2);
      exp_peak(2, 169);
      compare_all("single");

      // extreme value must not wrap
      send_frame(-32768, -32768, 0, 0, 0, 0, 0, 0);
      tick(7);
      exp_beat(0, -32768, -32768, 32'h8000_0000);
      exp_beat(1, 0, 0, 0); exp_beat(2, 0, 0, 0); exp_beat(3, 0, 0, 0);
      exp_peak(0, 32'h8000_0000);
      compare_all("extreme");

      // ties keep the lowest bin
      send_frame(0, 0, 0, 0, 0, 0, 0, 0);
      tick(7);
      exp_beat(0, 0, 0, 0); exp_beat(1, 0, 0, 0); exp_beat(2, 0, 0, 0); exp_beat(3, 0, 0, 0);
      exp_peak(0, 0);
      compare_all("tie_zero");
      send_frame(2, 0, 0, 2, -2, 0, 0, -2);
      tick(7);
      exp_beat(0, 2, 0, 4); exp_beat(1, 0, 2, 4); exp_beat(2, -2, 0, 4); exp_beat(3, 0, -2, 4);
      exp_peak(0, 4);
      compare_all("tie_four");

      // backpressure fills the buffer, third frame dropped
      m_ready = 1'b0;
      send_frame(1, 0, 0, 1, 1, 1, 2, 0);
      send_frame(-1, -1, 3, 0, 0, -3, 1, 2);
      check("full_ready", 64'(frame_ready), 64'd0);
      check("full_bin0", 64'(m_bin), 64'd0);
      check("full_pwr0", 64'(m_power), 64'd1);
      send_frame(7, 7, 7, 7, 7, 7, 7, 7);
      check("drop_pulse", 64'(frame_drop), 64'd1);
      tick(1);
      check("drop_clear", 64'(frame_drop), 64'd0);
      tick(3);
      m_ready = 1'b1;
      tick(10);
      check("full_drained", 64'(frame_ready), 64'd1);
      check("ndrops", 64'(n_drops), 64'd1);
      exp_beat(0, 1, 0, 1); exp_beat(1, 0, 1, 1); exp_beat(2, 1, 1, 2); exp_beat(3, 2, 0, 4);
      exp_beat(0, -1, -1, 2); exp_beat(1, 3, 0, 9); exp_beat(2, 0, -3, 9); exp_beat(3, 1, 2, 5);
      exp_peak(3, 4); exp_peak(1, 9);
      compare_all("bp");

      // back-to-back frames every 4 cycles
      send_frame(0, 0, 0, 0, 0, 0, 6, 8);
      tick(3);
      send_frame(-3, -4, 4, 3, 0, 5, 5, 0);
      tick(3);
      send_frame(10, 0, 0, -1, -2, -2, 0, 0);
      tick(8);
      check("b2b_ndrops", 64'(n_drops), 64'd1);
      exp_beat(0, 0, 0, 0); exp_beat(1, 0, 0, 0); exp_beat(2, 0, 0, 0); exp_beat(3, 6, 8, 100);
      exp_beat(0, -3, -4, 25); exp_beat(1, 4, 3, 25); exp_beat(2, 0, 5, 25); exp_beat(3, 5, 0, 25);
      exp_beat(0, 10, 0, 100); exp_beat(1, 0, -1, 1); exp_beat(2, -2, -2, 8); exp_beat(3, 0, 0, 0);
      exp_peak(3, 100); exp_peak(0, 25); exp_peak(0, 100);
      compare_all("b2b");

      // reset during bin1 of frame 1 with frame 2 queued
      send_frame(5, 5, 6, 6, 7, 7, 8, 8);
      send_frame(1, 1, 1, 1, 1, 1, 1, 1);
      tick(1);
      check("mid_bin1", 64'(m_bin), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_m_valid", 64'(m_valid), 64'd0);
      check("mid_m_bin", 64'(m_bin), 64'd0);
      check("mid_m_pwr", 64'(m_power), 64'd0);
      check("mid_peak_pwr", 64'(peak_power), 64'd0);
      check("mid_ready", 64'(frame_ready), 64'd1);
      tick(1);
      rst = 1'b0;
      tick(2);
      check("post_rst_idle", 64'(m_valid), 64'd0);
      got_beats.delete();
      compare_all("mid_rst");
      send_frame(9, 12, 1, 0, 0, 0, -1, -1);
      tick(7);
      exp_beat(0, 9, 12, 225); exp_beat(1, 1, 0, 1); exp_beat(2, 0, 0, 0); exp_beat(3, -1, -1, 2);
      exp_peak(0, 225);
      compare_all("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
